// File: rtl/layer_priority_ctrl.sv
// layer_priority_ctrl: per-pixel layer arbiter with a double-buffered priority table.
// Game logic writes a shadow table through a valid/ready handshake and commits it;
// the shadow is copied to the active table only at the next frame boundary.
// Optional blink support is built when LAYER_BLINK_EN is defined.
module layer_priority_ctrl #(
    parameter int unsigned N_LAYERS     = 10,
    parameter int unsigned BLINK_FRAMES = 16
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                startOfFrame,
    input  logic [N_LAYERS-1:0] layerReq,
    input  logic [N_LAYERS-1:0] blinkMask,
    input  logic                cfgValid,
    output logic                cfgReady,
    input  logic [3:0]          cfgSlot,
    input  logic [3:0]          cfgLayer,
    input  logic                cfgCommit,
    output logic                tableDirty,
    output logic                winValid,
    output logic [3:0]          winLayer
);

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StCopy
    } cfg_state_e;

    cfg_state_e state_q, state_d;

    logic [3:0]  shadow_q [N_LAYERS];
    logic [3:0]  active_q [N_LAYERS];

    logic        wr_en;
    logic        blink_phase;
    logic [15:0] eligible;
    logic        win_found;
    logic [3:0]  win_layer;
    logic        win_valid_q;
    logic [3:0]  win_layer_q;

    // Config FSM next-state and handshake outputs
    always_comb begin
        state_d    = state_q;
        cfgReady   = 1'b0;
        tableDirty = 1'b1;
        unique case (state_q)
            StIdle: begin
                cfgReady   = 1'b1;
                tableDirty = 1'b0;
                if (cfgCommit) state_d = StArmed;
            end
            StArmed: begin
                // A commit seen together with startOfFrame lands here first, so the
                // copy always waits for a later frame pulse.
                if (startOfFrame) state_d = StCopy;
            end
            StCopy: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Writes to slots beyond the table are accepted but dropped
    assign wr_en = (state_q == StIdle) && cfgValid && (32'(cfgSlot) < N_LAYERS);

    // Config FSM state register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Shadow table takes handshake writes; active table reloads during COPY
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int s = 0; s < N_LAYERS; s++) begin
                shadow_q[s] <= 4'(s);
                active_q[s] <= 4'(s);
            end
        end else begin
            for (int s = 0; s < N_LAYERS; s++) begin
                if (wr_en && (cfgSlot == 4'(s))) shadow_q[s] <= cfgLayer;
            end
            if (state_q == StCopy) begin
                for (int s = 0; s < N_LAYERS; s++) begin
                    active_q[s] <= shadow_q[s];
                end
            end
        end
    end

`ifdef LAYER_BLINK_EN
    localparam int unsigned CntW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CntW-1:0] frame_cnt_q;
    logic            blink_phase_q;

    // Frame counter; the phase toggles on each wrap
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (startOfFrame) begin
            if (frame_cnt_q == CntW'(BLINK_FRAMES - 1)) begin
                frame_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                frame_cnt_q <= frame_cnt_q + CntW'(1);
            end
        end
    end

    assign blink_phase = blink_phase_q;
`else
    assign blink_phase = 1'b0;
`endif

    // Per-layer eligibility; indices >= N_LAYERS stay 0 so they can never win
    always_comb begin
        eligible = '0;
        for (int l = 0; l < N_LAYERS; l++) begin
            eligible[l] = layerReq[l] & ~(blink_phase & blinkMask[l]);
        end
    end

    // Priority scan: first slot holding an eligible layer wins
    always_comb begin
        win_found = 1'b0;
        win_layer = '0;
        for (int s = 0; s < N_LAYERS; s++) begin
            if (!win_found && eligible[active_q[s]]) begin
                win_found = 1'b1;
                win_layer = active_q[s];
            end
        end
    end

    // Registered arbitration result, one cycle latency
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            win_valid_q <= 1'b0;
            win_layer_q <= '0;
        end else begin
            win_valid_q <= win_found;
            win_layer_q <= win_layer;
        end
    end

    assign winValid = win_valid_q;
    assign winLayer = win_layer_q;

endmodule

// File: tb/tb_layer_priority_ctrl.sv
// Self-checking bench for layer_priority_ctrl: directed vector table, randomized
// traffic against a behavioural model, and hand sequences for reset and blink.
module tb_layer_priority_ctrl;

    localparam int N  = 10;
    localparam int BF = 2;
`ifdef LAYER_BLINK_EN
    localparam bit BlinkOn = 1'b1;
`else
    localparam bit BlinkOn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         resetN = 1'b1;
    logic         startOfFrame = 1'b0;
    logic [N-1:0] layerReq = '0;
    logic [N-1:0] blinkMask = '0;
    logic         cfgValid = 1'b0;
    logic         cfgReady;
    logic [3:0]   cfgSlot = '0;
    logic [3:0]   cfgLayer = '0;
    logic         cfgCommit = 1'b0;
    logic         tableDirty;
    logic         winValid;
    logic [3:0]   winLayer;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int m_shadow[N];
    int m_active[N];
    bit m_pending;
    bit m_copying;
    bit m_phase;
    int m_frames;

    always #5 clk = ~clk;

    layer_priority_ctrl #(
        .N_LAYERS    (N),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .layerReq    (layerReq),
        .blinkMask   (blinkMask),
        .cfgValid    (cfgValid),
        .cfgReady    (cfgReady),
        .cfgSlot     (cfgSlot),
        .cfgLayer    (cfgLayer),
        .cfgCommit   (cfgCommit),
        .tableDirty  (tableDirty),
        .winValid    (winValid),
        .winLayer    (winLayer)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_shadow[i] = i;
            m_active[i] = i;
        end
        m_pending = 1'b0;
        m_copying = 1'b0;
        m_phase   = 1'b0;
        m_frames  = 0;
    endtask

    task automatic clear_inputs();
        startOfFrame = 1'b0;
        cfgValid     = 1'b0;
        cfgCommit    = 1'b0;
        cfgSlot      = '0;
        cfgLayer     = '0;
    endtask

    // One clock: check handshake outputs before the edge, advance the model,
    // then check the registered winner just after the edge.
    task automatic cycle(output bit rdy_s, output bit dty_s);
        bit busy;
        bit found;
        int win;
        int l;
        @(negedge clk);
        busy  = m_pending || m_copying;
        rdy_s = cfgReady;
        dty_s = tableDirty;
        check("cfgReady", int'(cfgReady), int'(!busy));
        check("tableDirty", int'(tableDirty), int'(busy));
        found = 1'b0;
        win   = 0;
        for (int s = 0; s < N; s++) begin
            l = m_active[s];
            if (!found && l < N && layerReq[l] && !(BlinkOn && m_phase && blinkMask[l])) begin
                found = 1'b1;
                win   = l;
            end
        end
        if (!busy && cfgValid && cfgSlot < N) m_shadow[cfgSlot] = int'(cfgLayer);
        if (m_copying) begin
            for (int s = 0; s < N; s++) m_active[s] = m_shadow[s];
            m_copying = 1'b0;
        end else if (m_pending) begin
            if (startOfFrame) begin
                m_pending = 1'b0;
                m_copying = 1'b1;
            end
        end else if (cfgCommit) begin
            m_pending = 1'b1;
        end
        if (startOfFrame) begin
            m_frames++;
            if (m_frames == BF) begin
                m_frames = 0;
                m_phase  = !m_phase;
            end
        end
        @(posedge clk);
        #1;
        check("winValid", int'(winValid), int'(found));
        check("winLayer", int'(winLayer), win);
    endtask

    task automatic do_reset();
        clear_inputs();
        resetN = 1'b0;
        #3;
        check("rst winValid", int'(winValid), 0);
        check("rst winLayer", int'(winLayer), 0);
        check("rst cfgReady", int'(cfgReady), 1);
        check("rst tableDirty", int'(tableDirty), 0);
        model_reset();
        @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] req;
        bit           cv;
        int           slot;
        int           lay;
        bit           commit;
        bit           sof;
        bit           e_ready;
        bit           e_dirty;
        bit           e_valid;
        int           e_layer;
    } vec_t;

    vec_t vecs[14];
    int   bexp[5];

    initial begin
        bit r;
        bit d;

        vecs[0]  = '{10'b0000000110, 0, 0, 0, 0, 0, 1, 0, 1, 1};
        vecs[1]  = '{10'b0000000000, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        vecs[2]  = '{10'b0000000000, 1, 0, 9, 0, 0, 1, 0, 0, 0};
        vecs[3]  = '{10'b0000000000, 1, 9, 0, 0, 0, 1, 0, 0, 0};
        vecs[4]  = '{10'b1000000001, 0, 0, 0, 1, 0, 1, 0, 1, 0};
        vecs[5]  = '{10'b1000000001, 0, 0, 0, 0, 0, 0, 1, 1, 0};
        vecs[6]  = '{10'b1000000001, 0, 0, 0, 0, 1, 0, 1, 1, 0};
        vecs[7]  = '{10'b1000000001, 0, 0, 0, 0, 0, 0, 1, 1, 0};
        vecs[8]  = '{10'b1000000001, 0, 0, 0, 0, 0, 1, 0, 1, 9};
        vecs[9]  = '{10'b0000000011, 1, 1, 0, 1, 1, 1, 0, 1, 1};
        vecs[10] = '{10'b0000000011, 0, 0, 0, 0, 0, 0, 1, 1, 1};
        vecs[11] = '{10'b0000000011, 0, 0, 0, 0, 1, 0, 1, 1, 1};
        vecs[12] = '{10'b0000000011, 0, 0, 0, 0, 0, 0, 1, 1, 1};
        vecs[13] = '{10'b0000000011, 0, 0, 0, 0, 0, 1, 0, 1, 0};

        #1;
        do_reset();

        // Directed table: basic arbitration, swap, commit coinciding with frame pulse
        for (int i = 0; i < 14; i++) begin
            layerReq     = vecs[i].req;
            cfgValid     = vecs[i].cv;
            cfgSlot      = 4'(vecs[i].slot);
            cfgLayer     = 4'(vecs[i].lay);
            cfgCommit    = vecs[i].commit;
            startOfFrame = vecs[i].sof;
            cycle(r, d);
            check($sformatf("vec%0d ready", i), int'(r), int'(vecs[i].e_ready));
            check($sformatf("vec%0d dirty", i), int'(d), int'(vecs[i].e_dirty));
            check($sformatf("vec%0d winValid", i), int'(winValid), int'(vecs[i].e_valid));
            check($sformatf("vec%0d winLayer", i), int'(winLayer), vecs[i].e_layer);
        end
        clear_inputs();

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) blinkMask = N'($urandom);
            layerReq     = N'($urandom);
            cfgValid     = 1'($urandom_range(0, 1));
            cfgSlot      = 4'($urandom_range(0, 15));
            cfgLayer     = 4'($urandom_range(0, 15));
            cfgCommit    = ($urandom_range(0, 9) == 0);
            startOfFrame = ($urandom_range(0, 15) == 0);
            cycle(r, d);
        end
        clear_inputs();
        blinkMask = '0;

        // Reset while ARMED: table back to identity, FSM idle
        for (int i = 0; i < 10; i++) begin
            if (!m_pending) begin
                cfgValid  = 1'b1;
                cfgSlot   = 4'd0;
                cfgLayer  = 4'd9;
                cfgCommit = 1'b1;
                cycle(r, d);
            end
        end
        clear_inputs();
        cycle(r, d);
        check("armed dirty", int'(d), 1);
        do_reset();
        layerReq = 10'b1000000001;
        cycle(r, d);
        check("post-rst ready", int'(r), 1);
        check("post-rst dirty", int'(d), 0);
        check("post-rst identity", int'(winLayer), 0);

        // Out-of-range slot write is accepted and dropped
        cfgValid = 1'b1;
        cfgSlot  = 4'd12;
        cfgLayer = 4'd5;
        cycle(r, d);
        check("slot12 ready", int'(r), 1);
        cfgValid  = 1'b0;
        cfgCommit = 1'b1;
        cycle(r, d);
        cfgCommit    = 1'b0;
        startOfFrame = 1'b1;
        cycle(r, d);
        startOfFrame = 1'b0;
        cycle(r, d);
        layerReq = 10'b1000100001;
        cycle(r, d);
        check("slot12 identity", int'(winLayer), 0);

        // Blink: layer 0 blanked during odd blink half-periods
        do_reset();
        bexp      = '{0, 0, 1, 1, 0};
        blinkMask = 10'b0000000001;
        layerReq  = 10'b0000000011;
        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < 3; c++) begin
                cycle(r, d);
                check($sformatf("blink frame%0d", p), int'(winLayer), BlinkOn ? bexp[p] : 0);
            end
            startOfFrame = 1'b1;
            cycle(r, d);
            startOfFrame = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_priority_ctrl.md
# layer_priority_ctrl

Programmable layer-priority arbiter that decides, pixel by pixel, which drawing layer owns the VGA output. It sits between the per-object drawing-request generators and the RGB output multiplexer. Each cycle it returns the index of the winning layer, and the multiplexer forwards that layer's RGB. Game logic can reorder layers, for example raising the death overlay or lowering the hoops, through a write handshake. A new order takes effect only at a frame boundary, so a frame is never drawn half in the old order and half in the new one.

## Interface
Parameters:
- N_LAYERS, 10, number of layers; must be ≤ 16
- BLINK_FRAMES, 16, frames per blink half-period; must be ≥ 1

Ports:
- clk  in  1  pixel clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse in vertical blanking, once per frame
- layerReq  in  N_LAYERS  drawing requests; bit i is layer i
- blinkMask  in  N_LAYERS  layers that blink
- cfgValid  in  1  config write request
- cfgReady  out  1  config write accepted when high together with cfgValid
- cfgSlot  in  4  priority slot to write; slot 0 is highest priority
- cfgLayer  in  4  layer index to place in that slot
- cfgCommit  in  1  one-cycle pulse: shadow table is complete
- tableDirty  out  1  a commit is pending
- winValid  out  1  some layer is requesting this pixel
- winLayer  out  4  index of the winning layer

## Operation
- Two tables of N_LAYERS 4-bit entries:
  - active table: drives arbitration.
  - shadow table: receives writes.
  - Reset value of both: slot i = layer i (identity order).
- Config FSM has three states, IDLE, ARMED and COPY. Reset state is IDLE.
- IDLE:
  - cfgReady=1.
  - A write completes on cfgValid&cfgReady: shadow[cfgSlot] <= cfgLayer.
  - cfgSlot ≥ N_LAYERS: the write is accepted and dropped.
  - cfgCommit → ARMED. If cfgValid is high in the same cycle, that write lands first.
- ARMED:
  - cfgReady=0 and tableDirty=1.
  - cfgCommit is ignored.
  - startOfFrame → COPY.
  - cfgCommit and startOfFrame together while in IDLE: go to ARMED only. The copy waits for the next startOfFrame.
- COPY:
  - Lasts one cycle; cfgReady=0 and tableDirty=1.
  - active <= shadow, then → IDLE.
- Arbitration:
  - Scan slots 0 to N_LAYERS-1 and take the first slot whose layer L satisfies L < N_LAYERS, layerReq[L]=1 and L is not blanked.
  - Blanked means blinkPhase=1 and blinkMask[L]=1.
  - Duplicate entries are legal; the first occurrence decides.
  - A layer that appears in no slot never wins.
  - No winner: winValid=0 and winLayer=0. The multiplexer then shows the background.
- Blink:
  - frameCnt counts startOfFrame pulses from 0 to BLINK_FRAMES-1.
  - On wrap, frameCnt returns to 0 and blinkPhase toggles.
  - Reset values: frameCnt=0, blinkPhase=0.

## Timing
- Reset values: winValid=0, winLayer=0, tableDirty=0, cfgReady=1.
- winValid and winLayer are registered: the result for layerReq sampled at edge n appears after edge n.
- Latency is exactly 1 cycle, with no bubbles.
- A new active table affects the arbitration result registered at the edge after the COPY cycle. The COPY cycle itself uses the old table.
- blinkPhase changes at the edge that samples the wrapping startOfFrame. It applies from the next cycle.
- A commit that reaches ARMED takes effect at the first startOfFrame sampled in a later cycle. Worst case is one full frame.
- Reset asserted mid-operation:
  - Both tables return to identity and the FSM goes to IDLE.
  - Blink state is cleared.
  - Pending writes are lost.

## Configuration
- Macro: LAYER_BLINK_EN.
- Defined: blink counter, blinkPhase and suppression are implemented as described above.
- Undefined:
  - The counter and phase logic is not built.
  - The blinkMask port remains but is ignored.
  - Arbitration never blanks a layer, so blinkPhase is effectively 0.

## Test plan
- Reset then layerReq=10'b0000000110 → winValid=1, winLayer=1 on the next cycle. layerReq=0 → winValid=0, winLayer=0.
- Swap order:
  - Stimulus: write slot0=9 and slot9=0, pulse cfgCommit, then hold layerReq=10'b1000000001.
  - Before startOfFrame: winLayer=0 and tableDirty=1.
  - After the COPY cycle: winLayer=9, tableDirty=0, cfgReady=1.
- Pulse cfgCommit and startOfFrame in the same cycle → the state is ARMED and the table is unchanged. The next startOfFrame copies the table.
- Write with cfgSlot=12 → cfgReady=1, the shadow table is unchanged, and a later commit leaves identity order.
- With LAYER_BLINK_EN, BLINK_FRAMES=2, blinkMask=10'b1, layerReq=10'b11:
  - Frames 0–1: winLayer=0.
  - After the 2nd pulse, frames 2–3: winLayer=1.
  - After the 4th pulse: winLayer=0.
  - Without the macro: winLayer=0 always.
- Assert resetN low while ARMED → after release the FSM is in IDLE, tableDirty=0, and the order is identity.
